// File: rtl/xgriscv_muldiv_div_if.sv
// Bus between the execute-stage issue logic and the iterative divider.
//
// Handshake: the master raises start for one cycle with op/a/b valid; the
// divider accepts it only when busy=0 and flush=0 (busy acts as not-ready).
// A start seen while busy=1 or together with flush is dropped, not queued.
// done is a one-cycle valid strobe for result; there is no backpressure on
// done, so the master must capture result on that cycle or later, before
// the next accepted operation completes.
interface xgriscv_muldiv_div_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [1:0]      fsm_state;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result, fsm_state
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result, fsm_state
    );
endinterface

// File: rtl/xgriscv_muldiv_div.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Works on operand magnitudes, one quotient bit per cycle, then a single
// sign-fix cycle. Divide-by-zero and signed overflow finish in one cycle.
module xgriscv_muldiv_div #(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    xgriscv_muldiv_div_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] rem_q;     // partial remainder
    logic [XLEN-1:0] quo_q;     // dividend shifts out the top, quotient shifts in the bottom
    logic [XLEN-1:0] dvs_q;     // divisor magnitude
    logic [XLEN-1:0] result_q;
    logic [CNTW-1:0] cnt_q;

    logic            busy;
    logic            accept;
    logic            in_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] fix_res;

    assign busy          = (state == CALC) || (state == FIX);
    assign bus.busy      = busy;
    assign bus.done      = (state == DONE);
    assign bus.result    = result_q;
    assign bus.fsm_state = state;

    // Operand capture: magnitudes, sign bits and the single-cycle special cases.
    always_comb begin
        accept      = bus.start && !busy && !bus.flush;
        in_signed   = !bus.op[0];
        a_neg       = in_signed && bus.a[XLEN-1];
        b_neg       = in_signed && bus.b[XLEN-1];
        abs_a       = a_neg ? (~bus.a + 1'b1) : bus.a;
        abs_b       = b_neg ? (~bus.b + 1'b1) : bus.b;
        div_zero    = (bus.b == '0);
        overflow    = in_signed && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = bus.op[1] ? bus.a : '1;
        end else if (overflow) begin
            special_res = bus.op[1] ? '0 : bus.a;
        end
    end

    // One restoring step: shift {rem, dividend} left, trial-subtract, keep if non-negative.
    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, dvs_q};
        q_bit    = !diff[XLEN];
        rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_next = {quo_q[XLEN-2:0], q_bit};
    end

    // Sign correction: quotient negative on sign mismatch, remainder follows the dividend.
    always_comb begin
        fix_res = '0;
        if (op_q[1]) begin
            fix_res = (!op_q[0] && sign_a) ? (~rem_q + 1'b1) : rem_q;
        end else begin
            fix_res = (!op_q[0] && (sign_a != sign_b)) ? (~quo_q + 1'b1) : quo_q;
        end
    end

    // Control FSM and datapath registers; result only changes when entering DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q   <= bus.op;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        quo_q  <= abs_a;
                        dvs_q  <= abs_b;
                        rem_q  <= '0;
                        cnt_q  <= CNTW'(XLEN - 1);
                        if (div_zero || overflow) begin
                            result_q <= special_res;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_res;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xgriscv_muldiv_div.sv
// Directed bench for the iterative divider: latency, results, special
// cases, busy/flush handling, back-to-back issue and mid-operation reset.
module tb_xgriscv_muldiv_div;

    localparam int XLEN = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    xgriscv_muldiv_div_if #(.XLEN(XLEN)) bus ();

    xgriscv_muldiv_div #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle (cycle k); returns positioned in cycle k+1
    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.flush = 1'b0;
        tick();
        bus.start = 1'b0;
    endtask

    // Passive monitor over a bounded window; cycle 1 is the current cycle
    task automatic observe(input int max_cycles, output int lat, output int busy_cnt,
                           output int busy_first, output int busy_last, output int done_cnt);
        lat = 0; busy_cnt = 0; busy_first = 0; busy_last = 0; done_cnt = 0;
        for (int n = 1; n <= max_cycles; n++) begin
            if (bus.busy) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = n;
                busy_last = n;
            end
            if (bus.done) begin
                done_cnt++;
                if (lat == 0) lat = n;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        repeat (2) tick();
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
        checks++; if (bus.fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.fsm_state); end
    endtask

    task automatic test_unsigned();
        int lat, bc, bf, bl, dc;
        issue(2'b01, 32'd100, 32'd7);
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency: got %0d expected 34", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected 33", bc); end
        checks++; if (bf !== 1 || bl !== 33) begin errors++; $display("FAIL divu_busy_window: got %0d..%0d expected 1..33", bf, bl); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL divu_done_count: got %0d expected 1", dc); end
        checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL divu_result: got %h expected 0000000e", bus.result); end
        issue(2'b11, 32'd100, 32'd7);
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (lat !== 34) begin errors++; $display("FAIL remu_latency: got %0d expected 34", lat); end
        checks++; if (bus.result !== 32'd2) begin errors++; $display("FAIL remu_result: got %h expected 00000002", bus.result); end
    endtask

    task automatic test_signed();
        int lat, bc, bf, bl, dc;
        issue(2'b00, 32'hFFFF_FFF9, 32'd2);
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (lat !== 34) begin errors++; $display("FAIL div_neg_latency: got %0d expected 34", lat); end
        checks++; if (bus.result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg: got %h expected fffffffd", bus.result); end
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (bus.result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg: got %h expected ffffffff", bus.result); end
        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (bus.result !== 32'd1) begin errors++; $display("FAIL rem_negdiv: got %h expected 00000001", bus.result); end
        issue(2'b00, 32'd7, 32'hFFFF_FFFE);
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (bus.result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdiv: got %h expected fffffffd", bus.result); end
        issue(2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (bus.result !== 32'd3) begin errors++; $display("FAIL div_bothneg: got %h expected 00000003", bus.result); end
    endtask

    task automatic test_div_by_zero();
        int lat, bc, bf, bl, dc;
        issue(2'b00, 32'd5, 32'd0);
        observe(10, lat, bc, bf, bl, dc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d expected 1", lat); end
        checks++; if (bc !== 0) begin errors++; $display("FAIL div0_busy: got %0d expected 0", bc); end
        checks++; if (bus.result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_result: got %h expected ffffffff", bus.result); end
        issue(2'b11, 32'd5, 32'd0);
        observe(10, lat, bc, bf, bl, dc);
        checks++; if (lat !== 1 || bc !== 0) begin errors++; $display("FAIL remu0_timing: got lat %0d busy %0d expected 1 0", lat, bc); end
        checks++; if (bus.result !== 32'd5) begin errors++; $display("FAIL remu0_result: got %h expected 00000005", bus.result); end
        issue(2'b10, 32'hFFFF_FFFB, 32'd0);
        observe(10, lat, bc, bf, bl, dc);
        checks++; if (bus.result !== 32'hFFFF_FFFB) begin errors++; $display("FAIL rem0_result: got %h expected fffffffb", bus.result); end
    endtask

    task automatic test_overflow();
        int lat, bc, bf, bl, dc;
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        observe(10, lat, bc, bf, bl, dc);
        checks++; if (lat !== 1 || bc !== 0) begin errors++; $display("FAIL ovf_timing: got lat %0d busy %0d expected 1 0", lat, bc); end
        checks++; if (bus.result !== 32'h8000_0000) begin errors++; $display("FAIL ovf_div: got %h expected 80000000", bus.result); end
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        observe(10, lat, bc, bf, bl, dc);
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL ovf_rem: got %h expected 00000000", bus.result); end
    endtask

    task automatic test_start_while_busy();
        int lat, bc, bf, bl, dc;
        issue(2'b01, 32'd100, 32'd7);
        repeat (4) tick();
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd1; bus.b = 32'd1;
        tick();
        bus.start = 1'b0;
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (lat !== 29) begin errors++; $display("FAIL busy_start_latency: got %0d expected 29", lat); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", dc); end
        checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL busy_start_result: got %h expected 0000000e", bus.result); end
    endtask

    task automatic test_flush();
        int lat, bc, bf, bl, dc;
        issue(2'b01, 32'd9, 32'd3);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL flush_abort: got busy %b done %b expected 0 0", bus.busy, bus.done); end
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (dc !== 0 || bc !== 0) begin errors++; $display("FAIL flush_quiet: got done %0d busy %0d expected 0 0", dc, bc); end
        checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL flush_result: got %h expected 0000000e", bus.result); end
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd3;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (dc !== 0 || bc !== 0) begin errors++; $display("FAIL flush_start: got done %0d busy %0d expected 0 0", dc, bc); end
        checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL flush_start_result: got %h expected 0000000e", bus.result); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, bf, bl, dc;
        bit found;
        issue(2'b01, 32'd100, 32'd7);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (bus.done) found = 1'b1;
            else tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL b2b_first_done: got timeout expected done within 50 cycles"); end
        checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL b2b_first_result: got %h expected 0000000e", bus.result); end
        issue(2'b01, 32'd9, 32'd3);
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
        checks++; if (bus.result !== 32'd3) begin errors++; $display("FAIL b2b_result: got %h expected 00000003", bus.result); end
    endtask

    task automatic test_reset_mid();
        int lat, bc, bf, bl, dc;
        issue(2'b01, 32'd100, 32'd7);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midreset_flags: got busy %b done %b expected 0 0", bus.busy, bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h expected 00000000", bus.result); end
        observe(40, lat, bc, bf, bl, dc);
        checks++; if (dc !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", dc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow();
        issue(2'b01, 32'd100, 32'd7);
        repeat (40) tick();
        test_start_while_busy();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xgriscv_muldiv_div.md
Name: xgriscv_muldiv_div

Overview:
- Iterative divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits beside the single-cycle combinational ALU in the execute stage. It serves the long-latency operations that the ALU cannot complete in one cycle.
- The decode/hazard logic issues an operation with a start pulse, stalls while busy is high, and captures the result on the done pulse.
- Restoring division on operand magnitudes: one quotient bit per cycle, then one sign-fix cycle.

Parameters:
- XLEN, 32, operand/result width; also sets the iteration count.
- CNTW, $clog2(XLEN), width of the iteration counter.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-high; one clock; same clk/reset names as the rest of the core
- start  input  1  request a divide; sampled only when busy=0
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start
- a  input  XLEN  dividend (rs1); sampled with start
- b  input  XLEN  divisor (rs2); sampled with start
- flush  input  1  pipeline kill; aborts any operation in flight
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result is valid
- result  output  XLEN  quotient or remainder; held until the next accepted start completes

Behaviour:
- States:
  - IDLE
  - CALC: iterates with a counter
  - FIX: sign correction
  - DONE: one cycle
- Reset: state=IDLE, busy=0, done=0, result=0, all internal registers cleared. Reset mid-operation aborts immediately and produces no done.
- busy = (state==CALC or state==FIX). done = (state==DONE).
- Accept condition: start=1, busy=0, flush=0. Start may therefore be accepted in IDLE or in DONE (back-to-back operations).
- Start while busy=1: ignored, with no effect on the operation in flight.
- On accept in cycle k:
  - Latch op, the sign of a, the sign of b, and the magnitudes |a| and |b|. Signed ops take the two's-complement absolute value; unsigned ops take the raw value.
  - Clear the partial remainder; counter = XLEN-1.
  - b==0 (any op): go to DONE in cycle k+1. Result is all-ones for DIV/DIVU, or a unchanged for REM/REMU.
  - Signed overflow (op 00 or 10, a=100..0, b=all-ones): go to DONE in cycle k+1. Result is a (0x80000000) for DIV, or 0 for REM.
  - Otherwise: go to CALC in cycle k+1.
- CALC step (per cycle):
  - Shift the {remainder, dividend} pair left by 1.
  - Trial-subtract the divisor from the remainder using an XLEN+1-bit subtract.
  - If the trial result is non-negative, keep it and shift in quotient bit 1; else shift in 0.
  - Decrement the counter; after the iteration with counter==0, go to FIX.
  - CALC therefore occupies cycles k+1 .. k+XLEN.
- FIX (cycle k+XLEN+1):
  - Quotient is negated iff op is signed and sign(a)!=sign(b).
  - Remainder is negated iff op is signed and sign(a)=1.
  - The selected value is written to result at the edge leaving FIX.
  - Next state is DONE.
- DONE (cycle k+XLEN+2 normally, k+1 for special cases):
  - done=1 for exactly one cycle.
  - Next state is CALC or DONE if a new start is accepted, else IDLE.
- result register:
  - Changes only at the edge entering DONE.
  - Holds its value through IDLE and through a subsequent operation until that operation's DONE.
- flush=1:
  - In any state, next state is IDLE and done does not pulse in the following cycle.
  - result is unchanged.
  - flush and start in the same cycle: flush wins, start is dropped.
- Latency:
  - Normal path: XLEN+2 cycles from start to done, i.e. 34 at XLEN=32; busy is high for XLEN+1 cycles.
  - Special cases: 1 cycle from start to done; busy never asserts.
- Widths:
  - All arithmetic is unsigned on magnitudes; sign handling is done only at capture and in FIX.
  - No X propagation: default assignments in all combinational blocks.

Test Plan:
- DIVU a=100, b=7 at cycle k -> busy=1 for cycles k+1..k+33, done=1 only at k+34, result=14. Repeat as REMU -> result=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). REM a=7, b=0xFFFFFFFE -> 1.
- DIV a=5, b=0 -> done at k+1, result=0xFFFFFFFF. REMU a=5, b=0 -> result=5. busy stays 0 throughout.
- DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000 at k+1. REM same operands -> 0.
- Busy/flush handling, using DIVU 100/7 at k:
  - Second start at k+5 with a=1, b=1 -> ignored; result=14.
  - New op flushed at cycle j+10 -> busy=0 at j+11, no done pulse, result still 14.
  - Flush and start together -> no accept.
- Back-to-back and reset:
  - Start asserted during the DONE cycle with DIVU 9/3 -> accepted; next done 34 cycles later with result=3.
  - reset at k+20 -> busy=0, done=0, result=0 next cycle; no later done.
